// File: rtl/soc_uart_tx_if.sv
// Byte push handshake between a producer and the UART transmitter FIFO.
// The producer owns data/valid; the transmitter answers with ready.
interface soc_uart_tx_if;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;

   modport master (
      output tx_data_i,
      output tx_valid_i,
      input  tx_ready_o
   );

   modport slave (
      input  tx_data_i,
      input  tx_valid_i,
      output tx_ready_o
   );
endinterface

// File: rtl/soc_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1/8E1/8O1/8N2 serializer with runtime baud divider.
// Line configuration is sampled once per frame, at the moment the head byte is popped.
module soc_uart_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic                          parity_en_i,
   input  logic                          parity_odd_i,
   input  logic                          stop2_i,
   soc_uart_tx_if.slave                  tx_bus,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = DIV_W + 1;
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]   level_reg;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] div_reg, div_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_reg, tx_next;
   logic             par_bit_reg, par_bit_next;
   logic             par_en_reg, par_en_next;
   logic             stop2_reg, stop2_next;

   logic             push, start_req;
   logic [7:0]       head;
   logic [CNT_W-1:0] eff_div, stop_load;

   assign tx_bus.tx_ready_o = (level_reg != FULL_LVL);
   assign push              = tx_bus.tx_valid_i && tx_bus.tx_ready_o;
   assign head              = mem[rd_ptr_reg];

   // A zero divider would never let a bit end, so it is promoted to one cycle per bit.
   assign eff_div   = (baud_div_i == '0) ? CNT_W'(1) : {1'b0, baud_div_i};
   assign stop_load = stop2_reg ? ({div_reg[CNT_W-2:0], 1'b0} - CNT_W'(1))
                                : (div_reg - CNT_W'(1));

   assign tx_o         = tx_reg;
   assign busy_o       = (state_reg != IDLE);
   assign fifo_level_o = level_reg;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = (cnt_reg == '0) ? cnt_reg : cnt_reg - CNT_W'(1);
      div_next     = div_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      tx_next      = tx_reg;
      par_bit_next = par_bit_reg;
      par_en_next  = par_en_reg;
      stop2_next   = stop2_reg;
      start_req    = 1'b0;

      case (state_reg)
         IDLE: begin
            tx_next   = 1'b1;
            start_req = (level_reg != '0);
         end
         START: begin
            if (cnt_reg == '0) begin
               state_next = DATA;
               cnt_next   = div_reg - CNT_W'(1);
               bit_next   = '0;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (cnt_reg == '0) begin
               cnt_next = div_reg - CNT_W'(1);
               if (bit_reg == 3'd7) begin
                  if (par_en_reg) begin
                     state_next = PARITY;
                     tx_next    = par_bit_reg;
                  end else begin
                     state_next = STOP;
                     tx_next    = 1'b1;
                     cnt_next   = stop_load;
                  end
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (cnt_reg == '0) begin
               state_next = STOP;
               tx_next    = 1'b1;
               cnt_next   = stop_load;
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (cnt_reg == '0) begin
               if (level_reg != '0) start_req = 1'b1;
               else                 state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (start_req) begin
         state_next   = START;
         cnt_next     = eff_div - CNT_W'(1);
         div_next     = eff_div;
         par_en_next  = parity_en_i;
         stop2_next   = stop2_i;
         par_bit_next = ^head ^ parity_odd_i;
         shift_next   = head;
         tx_next      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         div_reg     <= CNT_W'(1);
         bit_reg     <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
         par_bit_reg <= 1'b0;
         par_en_reg  <= 1'b0;
         stop2_reg   <= 1'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         div_reg     <= div_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
         par_bit_reg <= par_bit_next;
         par_en_reg  <= par_en_next;
         stop2_reg   <= stop2_next;
         if (push)      wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (start_req) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, start_req})
            2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
            2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Storage carries no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_reg] <= tx_bus.tx_data_i;
   end
endmodule
